// File: rtl/chash_ball_writer.sv
// chash_ball_writer
// Builds the sparse +/-1 challenge polynomial c in a two-channel packed
// coefficient RAM. The target region is cleared first. Then a stream of
// (position, sign) candidates goes through a read-modify-write pipeline.
// Candidates that land on an occupied slot are rejected. The build stops once
// WEIGHT coefficients have been accepted.

module chash_ball_writer #(
    parameter int N                 = 512,
    parameter int LANES             = 2,
    parameter int W0                = 24,
    parameter int W1                = 25,
    parameter int WEIGHT            = 19,
    parameter int AW                = 11,
    parameter logic [AW-1:0] BASE_ADDR = 11'h600,
    parameter logic [W0-1:0] NEG0   = 24'hFC0000,
    parameter logic [W1-1:0] NEG1   = 25'h1FC0000,
    localparam int PW               = $clog2(N),
    localparam int CW               = $clog2(WEIGHT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PW-1:0]         in_pos,
    input  logic                  in_sign,
    output logic                  rd_en,
    output logic [AW-1:0]         rd_addr,
    input  logic [LANES*W0-1:0]   rd_data0,
    input  logic [LANES*W1-1:0]   rd_data1,
    output logic                  wr_en,
    output logic [AW-1:0]         wr_addr,
    output logic [LANES*W0-1:0]   wr_data0,
    output logic [LANES*W1-1:0]   wr_data1,
    output logic                  busy,
    output logic                  done,
    output logic [CW-1:0]         acc_cnt,
    output logic [7:0]            rej_cnt
);

    localparam int LW     = $clog2(LANES);
    localparam int LWE    = (LW > 0) ? LW : 1;
    localparam int NWORDS = N / LANES;
    localparam int CIW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int SW     = CW + 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Control state
    logic [1:0]      state_q, state_d;
    logic [CIW-1:0]  clrIdx_q, clrIdx_d;
    logic [CW-1:0]   accCnt_q, accCnt_d;
    logic [7:0]      rejCnt_q, rejCnt_d;

    // Pipeline stage 1: read issue
    logic            s1Valid_q;
    logic [AW-1:0]   s1Word_q;
    logic [LWE-1:0]  s1Lane_q;
    logic            s1Sign_q;

    // Pipeline stage 2: read data returning from the RAM
    logic            s2Valid_q;
    logic [AW-1:0]   s2Word_q;
    logic [LWE-1:0]  s2Lane_q;
    logic            s2Sign_q;

    // Pipeline stage 3: slot check and write-back
    logic            s3Valid_q;
    logic [AW-1:0]   s3Word_q;
    logic [LWE-1:0]  s3Lane_q;
    logic            s3Sign_q;
    logic [LANES*W0-1:0] s3Data0_q;
    logic [LANES*W1-1:0] s3Data1_q;

    // Combinational helpers
    logic [AW-1:0]   candWord;
    logic [LWE-1:0]  candLane;
    logic            hazard;
    logic [SW-1:0]   inflight;
    logic [SW-1:0]   committed;
    logic            inReady;
    logic            accept;
    logic [W0-1:0]   oldLane0;
    logic [W1-1:0]   oldLane1;
    logic [LANES*W0-1:0] mergedWord0;
    logic [LANES*W1-1:0] mergedWord1;
    logic            slotEmpty;
    logic            s3Write;
    logic            clearing;

    // Decode the incoming candidate and decide whether it may enter the pipeline
    always_comb begin
        candWord  = BASE_ADDR + AW'(in_pos >> LW);
        candLane  = LWE'(in_pos & PW'(LANES - 1));
        hazard    = (s1Valid_q && (s1Word_q == candWord)) ||
                    (s2Valid_q && (s2Word_q == candWord)) ||
                    (s3Valid_q && (s3Word_q == candWord));
        inflight  = SW'(s1Valid_q) + SW'(s2Valid_q) + SW'(s3Valid_q);
        committed = SW'(accCnt_q) + inflight;
        inReady   = (state_q == ST_RUN) && (committed < SW'(WEIGHT)) && !hazard;
        accept    = inReady && in_valid;
    end

    // Pick out the addressed lane of the captured word and build the merged write word
    always_comb begin
        oldLane0    = '0;
        oldLane1    = '0;
        mergedWord0 = s3Data0_q;
        mergedWord1 = s3Data1_q;
        for (int k = 0; k < LANES; k++) begin
            if (s3Lane_q == LWE'(k)) begin
                oldLane0 = s3Data0_q[k*W0 +: W0];
                oldLane1 = s3Data1_q[k*W1 +: W1];
                mergedWord0[k*W0 +: W0] = s3Sign_q ? W0'(1) : NEG0;
                mergedWord1[k*W1 +: W1] = s3Sign_q ? W1'(1) : NEG1;
            end
        end
        slotEmpty = (oldLane0 == '0) && (oldLane1 == '0);
        s3Write   = s3Valid_q && slotEmpty;
        clearing  = (state_q == ST_CLEAR);
    end

    // Next-state logic for the build sequence and the accept/reject counters
    always_comb begin
        state_d  = state_q;
        clrIdx_d = clrIdx_q;
        accCnt_d = accCnt_q;
        rejCnt_d = rejCnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_CLEAR;
                    clrIdx_d = '0;
                    accCnt_d = '0;
                    rejCnt_d = '0;
                end
            end
            ST_CLEAR: begin
                clrIdx_d = clrIdx_q + CIW'(1);
                if (clrIdx_q == CIW'(NWORDS - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (s3Valid_q) begin
                    if (slotEmpty) begin
                        accCnt_d = accCnt_q + CW'(1);
                    end else if (rejCnt_q != 8'hFF) begin
                        rejCnt_d = rejCnt_q + 8'd1;
                    end
                end
                if ((accCnt_q == CW'(WEIGHT)) && !s1Valid_q && !s2Valid_q && !s3Valid_q) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; reset aborts any build in progress straight back to idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            clrIdx_q <= '0;
            accCnt_q <= '0;
            rejCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            clrIdx_q <= clrIdx_d;
            accCnt_q <= accCnt_d;
            rejCnt_q <= rejCnt_d;
        end
    end

    // Three-stage read-modify-write pipeline: issue read, capture data, check and write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1Valid_q <= 1'b0;
            s1Word_q  <= '0;
            s1Lane_q  <= '0;
            s1Sign_q  <= 1'b0;
            s2Valid_q <= 1'b0;
            s2Word_q  <= '0;
            s2Lane_q  <= '0;
            s2Sign_q  <= 1'b0;
            s3Valid_q <= 1'b0;
            s3Word_q  <= '0;
            s3Lane_q  <= '0;
            s3Sign_q  <= 1'b0;
            s3Data0_q <= '0;
            s3Data1_q <= '0;
        end else begin
            s1Valid_q <= accept;
            if (accept) begin
                s1Word_q <= candWord;
                s1Lane_q <= candLane;
                s1Sign_q <= in_sign;
            end
            s2Valid_q <= s1Valid_q;
            s2Word_q  <= s1Word_q;
            s2Lane_q  <= s1Lane_q;
            s2Sign_q  <= s1Sign_q;
            s3Valid_q <= s2Valid_q;
            s3Word_q  <= s2Word_q;
            s3Lane_q  <= s2Lane_q;
            s3Sign_q  <= s2Sign_q;
            if (s2Valid_q) begin
                s3Data0_q <= rd_data0;
                s3Data1_q <= rd_data1;
            end
        end
    end

    // Output drive; address and data buses are held at zero when their strobe is idle
    always_comb begin
        in_ready = inReady;
        rd_en    = s1Valid_q;
        rd_addr  = s1Valid_q ? s1Word_q : '0;
        wr_en    = clearing || s3Write;
        if (clearing) begin
            wr_addr = BASE_ADDR + AW'(clrIdx_q);
        end else if (s3Write) begin
            wr_addr = s3Word_q;
        end else begin
            wr_addr = '0;
        end
        wr_data0 = s3Write ? mergedWord0 : '0;
        wr_data1 = s3Write ? mergedWord1 : '0;
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_DONE);
        acc_cnt  = accCnt_q;
        rej_cnt  = rejCnt_q;
    end

endmodule
